// File: rtl/hamming_secded_rx.sv
// Receive side of the (16,11) extended Hamming link: deserializes frames,
// corrects single errors, flags double errors and keeps saturating stats.
module hamming_secded_rx #(
    parameter bit REQUIRE_SOF = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [10:0]      data_out,
    output logic             data_valid,
    output logic             err_corrected,
    output logic             err_double,
    output logic [3:0]       syndrome,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] dbl_count
);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        pos_q, pos_d;
    logic [15:0]       shift_q, shift_d;
    logic              done_q, done_d;

    logic              dv_q;
    logic [10:0]       data_q;
    logic              corr_q, dbl_q;
    logic [3:0]        syn_q;
    logic [CNT_W-1:0]  ccnt_q, dcnt_q;

    logic [3:0]        syn_c;
    logic              par_c;
    logic [15:0]       fixed_c;
    logic [10:0]       data_c;
    logic              corr_c, dbl_c;

    // Framing: place each bit at its codeword position; sof always restarts.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        if (din_valid) begin
            if (sof) begin
                shift_d[0] = din;
                pos_d      = 4'd1;
                state_d    = COLLECT;
            end else if (state_q == COLLECT) begin
                shift_d[pos_q] = din;
                pos_d          = pos_q + 4'd1;
                done_d         = (pos_q == 4'd15);
            end
        end
    end

    // Decode the completed frame held in the shift register.
    always_comb begin
        syn_c = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (shift_q[i]) begin
                syn_c = syn_c ^ 4'(i);
            end
        end
        par_c   = ^shift_q;
        fixed_c = shift_q;
        if (syn_c != 4'd0 && par_c) begin
            fixed_c[syn_c] = ~shift_q[syn_c];
        end
        data_c = {fixed_c[15:9], fixed_c[7:5], fixed_c[3]};
        corr_c = par_c;
        dbl_c  = (syn_c != 4'd0) && !par_c;
    end

    // Framing state plus registered decode results and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= REQUIRE_SOF ? HUNT : COLLECT;
            pos_q   <= 4'd0;
            shift_q <= 16'd0;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
            data_q  <= 11'd0;
            corr_q  <= 1'b0;
            dbl_q   <= 1'b0;
            syn_q   <= 4'd0;
            ccnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            dv_q    <= done_q;
            if (done_q) begin
                data_q <= data_c;
                corr_q <= corr_c;
                dbl_q  <= dbl_c;
                syn_q  <= syn_c;
                if (corr_c && ccnt_q != '1) begin
                    ccnt_q <= ccnt_q + CNT_W'(1);
                end
                if (dbl_c && dcnt_q != '1) begin
                    dcnt_q <= dcnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign data_out      = data_q;
    assign data_valid    = dv_q;
    assign err_corrected = corr_q;
    assign err_double    = dbl_q;
    assign syndrome      = syn_q;
    assign corr_count    = ccnt_q;
    assign dbl_count     = dcnt_q;

endmodule
